// File: rtl/control_division.sv
`default_nettype none
// ============================================================================
//  Module      : control_division
//  Description : Unsigned restoring divider sequencer. Captures a dividend
//                and a divisor on a start request, runs one shift-subtract
//                step per clock on a single (ANCHO+1)-bit subtractor, and
//                presents quotient/remainder with a one-cycle done pulse.
//                A zero divisor short-circuits to an error result.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_division #(
    parameter int ANCHO = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [ANCHO-1:0] dividendo,
    input  logic [ANCHO-1:0] divisor,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] residuo,
    output logic             error_div0
);

    localparam int                 c_CNT_W    = $clog2(ANCHO);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ANCHO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITERA = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Partial remainder only needs ANCHO bits at rest: after every step it is
    // strictly below the divisor. The shifted value T and the difference S
    // are ANCHO+1 bits wide because T can reach 2*divisor-1.
    logic [ANCHO-1:0]   r_rem;
    logic [ANCHO-1:0]   r_quo;
    logic [ANCHO:0]     r_div;
    logic [c_CNT_W-1:0] r_cnt;

    logic [ANCHO-1:0]   r_cociente;
    logic [ANCHO-1:0]   r_residuo;
    logic               r_error;

    logic [ANCHO:0]     w_t;
    logic [ANCHO:0]     w_diff;
    logic               w_borrow;
    logic [ANCHO-1:0]   w_rem_next;
    logic [ANCHO-1:0]   w_quo_next;
    logic               w_last;
    logic               w_div0;

    // One shift-subtract step. Since T < 2*D, a non-negative difference is
    // below 2^ANCHO, so the MSB of the wide difference is exactly the borrow.
    assign w_t        = {r_rem, r_quo[ANCHO-1]};
    assign w_diff     = w_t - r_div;
    assign w_borrow   = w_diff[ANCHO];
    assign w_rem_next = w_borrow ? w_t[ANCHO-1:0] : w_diff[ANCHO-1:0];
    assign w_quo_next = {r_quo[ANCHO-2:0], ~w_borrow};
    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_div0     = (divisor == '0);

    assign ocupado    = (r_state == S_ITERA);
    assign listo      = (r_state == S_FIN);
    assign cociente   = r_cociente;
    assign residuo    = r_residuo;
    assign error_div0 = r_error;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only from IDLE, finish after ANCHO steps.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (inicio) begin
                    w_state_next = w_div0 ? S_FIN : S_ITERA;
                end
            end
            S_ITERA: begin
                if (w_last) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers. Results are
    // only written on the edge that enters FIN, so they hold across captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_cociente <= '0;
            r_residuo  <= '0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inicio) begin
                        if (w_div0) begin
                            r_cociente <= '1;
                            r_residuo  <= dividendo;
                            r_error    <= 1'b1;
                        end else begin
                            r_rem <= '0;
                            r_quo <= dividendo;
                            r_div <= {1'b0, divisor};
                            r_cnt <= '0;
                        end
                    end
                end
                S_ITERA: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_cociente <= w_quo_next;
                        r_residuo  <= w_rem_next;
                        r_error    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_division.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_division
//  Description : Self-checking bench for control_division (ANCHO=5).
//                Expected results are queued at issue time and compared
//                when the done pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_division;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inicio = 1'b0;
    logic [W-1:0] dividendo = '0;
    logic [W-1:0] divisor = '0;
    logic         ocupado;
    logic         listo;
    logic [W-1:0] cociente;
    logic [W-1:0] residuo;
    logic         error_div0;

    int n_checks = 0;
    int n_fail = 0;
    int listo_pulses = 0;

    logic [2*W:0] exp_q[$];

    control_division #(.ANCHO(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inicio     (inicio),
        .dividendo  (dividendo),
        .divisor    (divisor),
        .ocupado    (ocupado),
        .listo      (listo),
        .cociente   (cociente),
        .residuo    (residuo),
        .error_div0 (error_div0)
    );

    always #5 clk = ~clk;

    // Count done pulses independently of the test sequence.
    always @(posedge clk) begin
        if (listo === 1'b1) listo_pulses <= listo_pulses + 1;
    end

    // Reference: {error, quotient, remainder}.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        q = a / b;
        r = a % b;
        return {1'b0, q, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted start (edge k), then scrambles operands.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dividendo = a;
        divisor   = b;
        inicio    = 1'b1;
        exp_q.push_back(model(a, b));
        step();
        inicio    = 1'b0;
        dividendo = W'($urandom);
        divisor   = W'($urandom);
    endtask

    // Bounded wait for the done pulse; lat counts edges after the start edge.
    task automatic wait_listo(output int lat);
        lat = 0;
        while (listo !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
        n_checks++; if (listo !== 1'b0) begin n_fail++; $display("FAIL reset_listo got=%b exp=0", listo); end
        n_checks++; if (cociente !== '0) begin n_fail++; $display("FAIL reset_cociente got=%0d exp=0", cociente); end
        n_checks++; if (residuo !== '0) begin n_fail++; $display("FAIL reset_residuo got=%0d exp=0", residuo); end
        n_checks++; if (error_div0 !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error_div0); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [2*W:0] e;
        issue(5'd13, 5'd3);
        for (int i = 0; i < W; i++) begin
            n_checks++;
            if (ocupado !== 1'b1 || listo !== 1'b0) begin
                n_fail++; $display("FAIL basic_busy cycle=%0d ocupado=%b listo=%b exp 1/0", i, ocupado, listo);
            end
            step();
        end
        n_checks++;
        if (listo !== 1'b1 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL basic_done listo=%b ocupado=%b exp 1/0", listo, ocupado);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL basic_result got q=%0d r=%0d e=%b exp q=%0d r=%0d e=%b",
                               cociente, residuo, error_div0, e[2*W-1:W], e[W-1:0], e[2*W]);
        end
        step();
        n_checks++; if (listo !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width listo=%b exp=0", listo); end
        step();
        n_checks++;
        if (cociente !== 5'd4 || residuo !== 5'd1) begin
            n_fail++; $display("FAIL basic_hold got q=%0d r=%0d exp q=4 r=1", cociente, residuo);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta[5] = '{5'd31, 5'd3, 5'd31, 5'd30, 5'd0};
        logic [W-1:0] tb[5] = '{5'd1,  5'd7, 5'd31, 5'd17, 5'd5};
        logic [2*W:0] e;
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i]);
            wait_listo(lat);
            n_checks++;
            if (listo !== 1'b1 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL bound_timeout %0d/%0d listo=%b", ta[i], tb[i], listo);
            end else begin
                e = exp_q.pop_front();
                if ({error_div0, cociente, residuo} !== e) begin
                    n_fail++; $display("FAIL bound_result %0d/%0d got q=%0d r=%0d e=%b exp q=%0d r=%0d e=%b",
                                       ta[i], tb[i], cociente, residuo, error_div0,
                                       e[2*W-1:W], e[W-1:0], e[2*W]);
                end
            end
            step();
        end
    endtask

    task automatic test_div0();
        logic [2*W:0] e;
        int lat;
        issue(5'd7, 5'd0);
        n_checks++;
        if (listo !== 1'b1 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL div0_latency listo=%b ocupado=%b exp 1/0", listo, ocupado);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL div0_result got q=%0d r=%0d e=%b exp q=31 r=7 e=1", cociente, residuo, error_div0);
        end
        step();
        issue(5'd9, 5'd2);
        n_checks++;
        if (cociente !== 5'd31 || residuo !== 5'd7 || error_div0 !== 1'b1) begin
            n_fail++; $display("FAIL div0_hold_on_capture got q=%0d r=%0d e=%b exp q=31 r=7 e=1",
                               cociente, residuo, error_div0);
        end
        wait_listo(lat);
        n_checks++;
        if (listo !== 1'b1 || lat != W) begin
            n_fail++; $display("FAIL div0_next_latency got=%0d exp=%0d", lat, W);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL div0_next_result got q=%0d r=%0d e=%b exp q=4 r=1 e=0", cociente, residuo, error_div0);
        end
        step();
    endtask

    task automatic test_ignore_inicio();
        logic [2*W:0] e;
        int lat;
        int p0;
        p0 = listo_pulses;
        issue(5'd13, 5'd3);
        step();
        dividendo = 5'd20;
        divisor   = 5'd4;
        inicio    = 1'b1;
        step();
        inicio    = 1'b0;
        wait_listo(lat);
        n_checks++;
        if (listo !== 1'b1) begin
            n_fail++; $display("FAIL ignore_timeout listo=%b exp=1", listo);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL ignore_result got q=%0d r=%0d exp q=4 r=1", cociente, residuo);
        end
        repeat (10) step();
        n_checks++;
        if (listo_pulses - p0 != 1 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL ignore_single_pulse pulses=%0d ocupado=%b exp 1/0", listo_pulses - p0, ocupado);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W:0] e;
        int lat;
        dividendo = 5'd9;
        divisor   = 5'd2;
        inicio    = 1'b1;
        exp_q.push_back(model(5'd9, 5'd2));
        exp_q.push_back(model(5'd9, 5'd2));
        step();
        wait_listo(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (listo !== 1'b1 || {error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL held_first listo=%b got q=%0d r=%0d exp q=4 r=1", listo, cociente, residuo);
        end
        step();
        n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap ocupado=%b exp=0", ocupado); end
        step();
        n_checks++; if (ocupado !== 1'b1) begin n_fail++; $display("FAIL held_restart ocupado=%b exp=1", ocupado); end
        inicio = 1'b0;
        wait_listo(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (listo !== 1'b1 || {error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL held_second listo=%b got q=%0d r=%0d exp q=4 r=1", listo, cociente, residuo);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [2*W:0] e;
        int lat;
        int p0;
        issue(5'd13, 5'd3);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if (ocupado !== 1'b0 || listo !== 1'b0 || cociente !== '0 || residuo !== '0 || error_div0 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs ocup=%b listo=%b q=%0d r=%0d e=%b exp all 0",
                               ocupado, listo, cociente, residuo, error_div0);
        end
        p0 = listo_pulses;
        repeat (8) step();
        n_checks++;
        if (listo_pulses != p0) begin
            n_fail++; $display("FAIL midreset_no_done pulses=%0d exp=0", listo_pulses - p0);
        end
        issue(5'd25, 5'd6);
        wait_listo(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (listo !== 1'b1 || {error_div0, cociente, residuo} !== e) begin
            n_fail++; $display("FAIL midreset_recover listo=%b got q=%0d r=%0d exp q=4 r=1", listo, cociente, residuo);
        end
        step();
    endtask

    task automatic test_sweep();
        logic [2*W:0] e;
        int lat;
        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 32; b++) begin
                issue(W'(a), W'(b));
                wait_listo(lat);
                n_checks++;
                if (listo !== 1'b1 || lat != W) begin
                    n_fail++; $display("FAIL sweep_latency %0d/%0d got=%0d exp=%0d", a, b, lat, W);
                end
                e = exp_q.pop_front();
                n_checks++;
                if ({error_div0, cociente, residuo} !== e) begin
                    n_fail++; $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d e=%b exp q=%0d r=%0d e=%b",
                                       a, b, cociente, residuo, error_div0, e[2*W-1:W], e[W-1:0], e[2*W]);
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div0();
        test_ignore_inicio();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
